// File: rtl/layer_stream_tx.sv
// layer_stream_tx: holds one IMG_DIM x IMG_DIM multi-channel image loaded by a host
// and streams it in raster order, one pixel per accepted cycle, to a downstream layer.
// Optional feature macro: LAYER_STREAM_TX_PAD_EN adds a PAD-pixel zero border.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_load_we/addr/data      host pixel write, accepted while o_ready
//   i_start                  begin a frame, accepted while o_ready
//   o_ready, o_done          idle/done indicator, pulse with the final beat
//   i_next_ready             downstream backpressure
//   o_next_data/we/start     registered downstream write interface
module layer_stream_tx #(
   parameter int DATA_SIZE = 8,
   parameter int CHANNELS  = 4,
   parameter int IMG_DIM   = 13,
   parameter int PAD       = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                i_load_we,
   input  logic [$clog2(IMG_DIM*IMG_DIM)-1:0]  i_load_addr,
   input  logic [CHANNELS-1:0][DATA_SIZE-1:0]  i_load_data,
   input  logic                                i_start,
   output logic                                o_ready,
   output logic                                o_done,
   input  logic                                i_next_ready,
   output logic [CHANNELS-1:0][DATA_SIZE-1:0]  o_next_data,
   output logic [CHANNELS-1:0]                 o_next_we,
   output logic                                o_next_start
);
   localparam int NPIX = IMG_DIM * IMG_DIM;
   localparam int AW = $clog2(NPIX);
`ifdef LAYER_STREAM_TX_PAD_EN
   localparam int W = IMG_DIM + 2 * PAD;
`else
   localparam int W = IMG_DIM;
`endif
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;
   typedef logic [CHANNELS-1:0][DATA_SIZE-1:0] pix_t;
   pix_t mem_q [NPIX];
   state_t state_q, state_d;
   logic [CW-1:0] row_q, row_d, col_q, col_d, r_in, c_in;
   pix_t data_q, data_d;
   logic we_q, we_d, start_q, start_d, done_q, done_d;
   logic beat, last, pad_pix;
   logic [AW-1:0] rd_addr;
`ifdef LAYER_STREAM_TX_PAD_EN
   localparam logic [CW-1:0] LO = CW'(PAD);
   localparam logic [CW-1:0] HI = CW'(PAD + IMG_DIM);
   assign r_in = row_q - LO;
   assign c_in = col_q - LO;
   assign pad_pix = row_q < LO || row_q >= HI || col_q < LO || col_q >= HI;
`else
   assign r_in = row_q;
   assign c_in = col_q;
   assign pad_pix = 1'b0;
`endif
   // border positions may form an out-of-range address; their data is forced to zero
   assign rd_addr = AW'(r_in) * AW'(IMG_DIM) + AW'(c_in);
   // DONE is held off o_ready during the o_done cycle so ready rises one cycle later
   assign o_ready = (state_q == IDLE || state_q == DONE) && !done_q;
   assign beat = state_q == STREAM && i_next_ready;
   assign last = row_q == LAST && col_q == LAST;
   assign o_done = done_q;
   assign o_next_data = data_q;
   assign o_next_we = {CHANNELS{we_q}};
   assign o_next_start = start_q;
   always_comb begin
      state_d = state_q;
      row_d = row_q;
      col_d = col_q;
      data_d = data_q;
      we_d = 1'b0;
      start_d = 1'b0;
      done_d = 1'b0;
      if (o_ready && i_start) begin
         state_d = START;
         start_d = 1'b1;
      end
      if (state_q == START) state_d = STREAM;
      if (beat) begin
         we_d = 1'b1;
         data_d = pad_pix ? '0 : mem_q[rd_addr];
         col_d = col_q == LAST ? '0 : col_q + 1'b1;
         row_d = col_q != LAST ? row_q : row_q == LAST ? '0 : row_q + 1'b1;
         done_d = last;
         state_d = last ? DONE : STREAM;
      end
   end
   // image storage survives reset
   always_ff @(posedge clk)
      if (i_load_we && o_ready && 32'(i_load_addr) < NPIX) mem_q[i_load_addr] <= i_load_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         row_q <= '0;
         col_q <= '0;
         data_q <= '0;
         we_q <= 1'b0;
         start_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q <= row_d;
         col_q <= col_d;
         data_q <= data_d;
         we_q <= we_d;
         start_q <= start_d;
         done_q <= done_d;
      end
endmodule

// File: tb/tb_layer_stream_tx.sv
// tb_layer_stream_tx: randomized self-checking bench for layer_stream_tx against a raster-order reference model
module tb_layer_stream_tx;
   localparam int DS = 8, CH = 2, D = 3, P = 1;
`ifdef LAYER_STREAM_TX_PAD_EN
   localparam int W = D + 2 * P;
`else
   localparam int W = D;
`endif
   localparam int AW = $clog2(D * D);
   typedef logic [CH-1:0][DS-1:0] pix_t;
   logic clk = 1'b0, rst = 1'b0, i_load_we = 1'b0, i_start = 1'b0, i_next_ready = 1'b0;
   logic [AW-1:0] i_load_addr = '0;
   pix_t i_load_data = '0;
   logic o_ready, o_done, o_next_start;
   pix_t o_next_data;
   logic [CH-1:0] o_next_we;
   pix_t mem_m [D*D];
   pix_t last_data = '0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   layer_stream_tx #(.DATA_SIZE(DS), .CHANNELS(CH), .IMG_DIM(D), .PAD(P)) dut (
      .clk(clk), .rst(rst), .i_load_we(i_load_we), .i_load_addr(i_load_addr),
      .i_load_data(i_load_data), .i_start(i_start), .o_ready(o_ready), .o_done(o_done),
      .i_next_ready(i_next_ready), .o_next_data(o_next_data), .o_next_we(o_next_we),
      .o_next_start(o_next_start)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic pix_t exp_pix(input int k);
      int r = k / W, c = k % W;
`ifdef LAYER_STREAM_TX_PAD_EN
      if (r < P || r >= P + D || c < P || c >= P + D) return '0;
      return mem_m[(r - P) * D + c - P];
`else
      return mem_m[r * D + c];
`endif
   endfunction
   task automatic load(input int addr, input pix_t d);
      i_load_we = 1'b1;
      i_load_addr = AW'(addr);
      i_load_data = d;
      tick();
      i_load_we = 1'b0;
      if (addr < D * D) mem_m[addr] = d;
   endtask
   // mode: 0 ready always high, 1 alternating starting low, 2 random
   task automatic run_frame(input int mode, input int abort_at, input int inject_at, input int pre_load);
      int k = 0, n = 0;
      pix_t v, nd = '0;
      logic rdy;
      i_start = 1'b1;
      if (pre_load >= 0) begin
         nd = 16'($urandom);
         i_load_we = 1'b1;
         i_load_addr = AW'(pre_load);
         i_load_data = nd;
      end
      tick();
      i_start = 1'b0;
      i_load_we = 1'b0;
      if (pre_load >= 0) mem_m[pre_load] = nd;
      check("start_pulse", o_next_start, 1);
      check("busy_ready", o_ready, 0);
      check("start_we", o_next_we, 0);
      i_next_ready = 1'b1;
      tick();
      check("start_once", o_next_start, 0);
      check("start_no_beat", o_next_we, 0);
      while (k < W * W && n < 8 * W * W) begin
         rdy = mode == 0 ? 1'b1 : mode == 1 ? n[0] : 1'($urandom);
         i_next_ready = rdy;
         if (n == inject_at) begin
            i_start = 1'b1;
            i_load_we = 1'b1;
            i_load_addr = '0;
            i_load_data = 16'd77;
         end
         tick();
         i_start = 1'b0;
         i_load_we = 1'b0;
         n++;
         check("no_restart", o_next_start, 0);
         if (rdy) begin
            v = exp_pix(k);
            check("beat_we", o_next_we, {CH{1'b1}});
            check("beat_data", o_next_data, v);
            check("beat_done", o_done, k == W * W - 1);
            check("beat_ready", o_ready, 0);
            last_data = v;
            k++;
         end else begin
            check("stall_we", o_next_we, 0);
            check("stall_hold", o_next_data, last_data);
            check("stall_done", o_done, 0);
         end
         if (k == abort_at) begin
            #2 rst = 1'b1;
            #1;
            check("rst_we", o_next_we, 0);
            check("rst_start", o_next_start, 0);
            check("rst_done", o_done, 0);
            check("rst_ready", o_ready, 1);
            check("rst_data", o_next_data, 0);
            last_data = '0;
            tick();
            rst = 1'b0;
            return;
         end
      end
      check("frame_len", k, W * W);
      i_next_ready = 1'b1;
      tick();
      check("post_ready", o_ready, 1);
      check("post_done", o_done, 0);
      check("post_we", o_next_we, 0);
   endtask
   initial begin
      #1 rst = 1'b1;
      tick();
      tick();
      check("reset_we", o_next_we, 0);
      check("reset_data", o_next_data, 0);
      check("reset_start", o_next_start, 0);
      check("reset_done", o_done, 0);
      check("reset_ready", o_ready, 1);
      rst = 1'b0;
      tick();
      for (int k = 0; k < D * D; k++) load(k, {8'(k), 8'(k + 100)});
      run_frame(0, -1, -1, -1);
      run_frame(1, -1, -1, -1);
      run_frame(0, -1, 3, -1);
      run_frame(2, -1, -1, -1);
      for (int k = 0; k < D * D; k++) load(k, 16'($urandom));
      run_frame(2, 4, -1, -1);
      run_frame(0, -1, -1, -1);
      load(9, 16'($urandom));
      load(15, 16'($urandom));
      run_frame(2, -1, -1, -1);
      run_frame(0, -1, -1, int'($urandom_range(0, D * D - 1)));
      for (int f = 0; f < 4; f++) begin
         load(int'($urandom_range(0, 15)), 16'($urandom));
         run_frame(2, -1, int'($urandom_range(0, 6)), -1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
